// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: walks a register file from first_reg to last_reg (wrapping
// modulo 2^ADDR_W) and streams each register out on a valid/ready port.
// Each word is snapshotted from the asynchronous read port in a one-cycle
// FETCH state, then presented in SEND until accepted.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin a dump (honoured only when idle)
//   first_reg/last_reg  inclusive index range, sampled with start
//   abort               cancel the current dump, return to idle next cycle
//   rf_raddr/rf_rdata   register file read index / combinational read data
//   out_valid/out_ready output handshake
//   out_data/out_idx    captured register value and its index
//   out_last            marks the final word of the dump
//   busy                high whenever not idle
//   done                one-cycle pulse after the final word is accepted
module rf_dump_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] curNext;
  logic [ADDR_W-1:0] lastReg;
  logic [ADDR_W-1:0] lastRegNext;
  logic              capture;

  // Read index always follows the current register pointer.
  assign rf_raddr = cur;

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    stateNext   = state;
    curNext     = cur;
    lastRegNext = lastReg;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext   = FETCH;
          curNext     = first_reg;
          lastRegNext = last_reg;
        end
      end
      FETCH: begin
        stateNext = SEND;
        capture   = 1'b1;
      end
      SEND: begin
        if (out_ready) begin
          if (out_last) begin
            stateNext = DONE;
          end else begin
            stateNext = FETCH;
            curNext   = cur + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    if (abort) begin
      stateNext   = IDLE;
      curNext     = cur;
      lastRegNext = lastReg;
      capture     = 1'b0;
    end
  end

  // State, pointer and registered outputs; status flags decode the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      lastReg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      cur       <= curNext;
      lastReg   <= lastRegNext;
      out_valid <= (stateNext == SEND);
      busy      <= (stateNext != IDLE);
      done      <= (stateNext == DONE);
      if (capture) begin
        out_data <= rf_rdata;
        out_idx  <= cur;
        out_last <= (cur == lastReg);
      end
    end
  end

endmodule

// File: doc/rf_dump_ctrl.md
RF_DUMP_CTRL -- requirements
Module: rf_dump_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request dump; sampled only in IDLE.
REQ-006 SHALL have port first_reg  input  ADDR_W  first register index to dump; sampled with start.
REQ-007 SHALL have port last_reg  input  ADDR_W  last register index to dump; sampled with start.
REQ-008 SHALL have port abort  input  1  cancel the dump in progress.
REQ-009 SHALL have port rf_raddr  output  ADDR_W  read index driven to the register file's asynchronous read port.
REQ-010 SHALL have port rf_rdata  input  DATA_W  combinational read data for rf_raddr.
REQ-011 SHALL have port out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-013 SHALL have port out_data  output  DATA_W  captured register value.
REQ-014 SHALL have port out_idx  output  ADDR_W  index of the register in out_data.
REQ-015 SHALL have port out_last  output  1  high with the final word of the dump.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-018 SHALL implement states IDLE, FETCH, SEND, DONE, held in a registered state variable.
REQ-019 SHALL in IDLE with start=1 and abort=0 latch first_reg/last_reg, set cur=first_reg and move to FETCH next cycle; start outside IDLE SHALL be ignored.
REQ-020 SHALL drive rf_raddr=cur in every state (cur=0 in IDLE after reset).
REQ-021 SHALL in FETCH register out_data<=rf_rdata, out_idx<=cur, out_last<=(cur==last), and move to SEND; FETCH lasts exactly one cycle.
REQ-022 SHALL assert out_valid only in SEND; out_data, out_idx, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 SHALL on out_valid&out_ready with out_last=0 set cur<=cur+1 modulo 2^ADDR_W and move to FETCH.
REQ-024 SHALL on out_valid&out_ready with out_last=1 move to DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 SHALL emit ((last_reg-first_reg) mod 2^ADDR_W)+1 words in ascending index order with wrap-around 31->0 when last_reg<first_reg.
REQ-026 SHALL emit exactly one word, with out_last=1, when first_reg==last_reg.
REQ-027 SHALL sustain one word per two cycles with out_ready held high (FETCH, SEND alternating).
REQ-028 SHALL snapshot each register at its FETCH cycle; register-file writes after that cycle SHALL NOT alter the held out_data.
REQ-029 SHALL on abort=1 in any state go to IDLE next cycle, deassert out_valid, and not pulse done; abort SHALL take priority over start and over a simultaneous handshake.
REQ-030 SHALL accept a new start in the IDLE cycle immediately following DONE.

Reset
REQ-031 SHALL on reset=1 at a clock edge enter IDLE and set cur=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, overriding start and abort.
REQ-032 SHALL when reset is asserted mid-dump discard the dump without pulsing done, and after reset deasserts emit no output until a new start.

Verification
REQ-033 SHALL verify a full dump: regs preloaded with k*0x11111111, start with first=0, last=31, out_ready=1 -> 32 words idx 0..31 with matching data, out_last only on idx 31, done pulse once, 64 cycles start-to-last-accept +/-1.
REQ-034 SHALL verify wrap: first=30, last=1 -> idx sequence 30,31,0,1; out_last on idx 1; exactly 4 words.
REQ-035 SHALL verify backpressure: first=last=5, reg5=0xDEADBEEF, out_ready low 10 cycles -> out_valid held, data stable 0xDEADBEEF; a write of 0x12345678 to reg5 during the stall is not reflected; one word accepted, done pulses.
REQ-036 SHALL verify abort: start first=0 last=31, abort after 3rd accept -> out_valid=0 and busy=0 next cycle, no done, next start dumps from its new first_reg.
REQ-037 SHALL verify reset mid-dump and ignored start: reset in SEND -> all outputs 0 next cycle; start pulsed while busy -> range unchanged, word count per REQ-025.
